// File: rtl/imm_gen.sv
// Immediate generator for the RV32I decode stage.
// Reassembles the immediate field of an instruction for the format chosen by
// the control unit, sign-extends it to WIDTH bits, and also provides a copy
// registered for one cycle for the pipelined datapath.

package cpu_pkg;

    // Datapath width shared across the core.
    localparam int WIDTH = 32;

    // Immediate format selector driven by the control unit.
    // The encodings 3'd5..3'd7 are unused and flagged as errors.
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

endpackage : cpu_pkg

module imm_gen
    import cpu_pkg::*;
#(
    // Datapath width. Must be at least 32.
    parameter int WIDTH = cpu_pkg::WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      instr_i,
    input  imm_src_e         imm_src_i,
    output logic [WIDTH-1:0] imm_o,
    output logic [WIDTH-1:0] imm_q_o,
    output logic             imm_src_err_o
);

    // Each format is first assembled as a 32-bit value. In every format bit 31
    // of that value is instr_i[31], so one signed widening at the end gives
    // the correct sign extension for all of them, including U-type when
    // WIDTH > 32.
    logic [31:0] imm_i_fmt;
    logic [31:0] imm_s_fmt;
    logic [31:0] imm_b_fmt;
    logic [31:0] imm_u_fmt;
    logic [31:0] imm_j_fmt;
    logic [31:0] imm32;

    // Assemble every format in parallel; only the selected one is used.
    always_comb begin
        imm_i_fmt = {{20{instr_i[31]}}, instr_i[31:20]};
        imm_s_fmt = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        imm_b_fmt = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
        imm_u_fmt = {instr_i[31:12], 12'h000};
        imm_j_fmt = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
    end

    // Select the format. A conditional chain is used instead of a case so
    // that an unknown selector shows up as X on the output instead of being
    // silently routed to the zero default.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a value
        // on every path (here the first statement), otherwise a latch is inferred.
        imm32 = 32'h0000_0000;
        imm32 = (imm_src_i == IMM_I) ? imm_i_fmt :
                (imm_src_i == IMM_S) ? imm_s_fmt :
                (imm_src_i == IMM_B) ? imm_b_fmt :
                (imm_src_i == IMM_U) ? imm_u_fmt :
                (imm_src_i == IMM_J) ? imm_j_fmt :
                                       32'h0000_0000;
    end

    // Sign-extend to the datapath width and flag undefined selector values.
    always_comb begin
        imm_o         = WIDTH'($signed(imm32));
        imm_src_err_o = (imm_src_i > IMM_J);
    end

    // One-cycle registered copy of the immediate; cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: registers are updated with non-blocking assignments so that
        // every flop samples values from before the clock edge.
        if (!rst_ni) begin
            imm_q_o <= '0;
        end else begin
            imm_q_o <= imm_o;
        end
    end

endmodule : imm_gen

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: a table of directed vectors for the
// combinational path, followed by hand-written reset/register sequences.

module tb_imm_gen;

    localparam int W = 32;

    logic                 clk_i;
    logic                 rst_ni;
    logic [31:0]          instr_i;
    cpu_pkg::imm_src_e    imm_src_i;
    logic [W-1:0]         imm_o;
    logic [W-1:0]         imm_q_o;
    logic                 imm_src_err_o;

    int total;
    int bad;

    imm_gen #(.WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .instr_i      (instr_i),
        .imm_src_i    (imm_src_i),
        .imm_o        (imm_o),
        .imm_q_o      (imm_q_o),
        .imm_src_err_o(imm_src_err_o)
    );

    // 10 ns clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] exp_imm;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Source codes: 0=I 1=S 2=B 3=U 4=J, 5..7 undefined.
        // I-type
        vecs.push_back('{32'h0010_0000, 3'd0, 32'h0000_0001, 1'b0});
        vecs.push_back('{32'hFFF0_0000, 3'd0, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{32'h7FF0_0000, 3'd0, 32'h0000_07FF, 1'b0});
        vecs.push_back('{32'h8000_0000, 3'd0, 32'hFFFF_F800, 1'b0});
        vecs.push_back('{32'h001F_FFFF, 3'd0, 32'h0000_0001, 1'b0}); // rs1/funct3/rd/opcode set
        // U-type
        vecs.push_back('{32'h0000_1000, 3'd3, 32'h0000_1000, 1'b0});
        vecs.push_back('{32'hABCD_E000, 3'd3, 32'hABCD_E000, 1'b0});
        vecs.push_back('{32'hABCD_EFFF, 3'd3, 32'hABCD_E000, 1'b0}); // low bits ignored
        // S-type
        vecs.push_back('{32'h0000_0080, 3'd1, 32'h0000_0001, 1'b0});
        vecs.push_back('{32'hFE00_0F80, 3'd1, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{32'h7E00_0F80, 3'd1, 32'h0000_07FF, 1'b0});
        vecs.push_back('{32'h8000_0000, 3'd1, 32'hFFFF_F800, 1'b0});
        vecs.push_back('{32'h01FF_F07F, 3'd1, 32'h0000_0000, 1'b0}); // rs2/rs1/funct3/opcode set
        // B-type
        vecs.push_back('{32'h0000_0100, 3'd2, 32'h0000_0002, 1'b0});
        vecs.push_back('{32'hFE00_0F80, 3'd2, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{32'h7E00_0F80, 3'd2, 32'h0000_0FFE, 1'b0});
        vecs.push_back('{32'h8000_0000, 3'd2, 32'hFFFF_F000, 1'b0});
        vecs.push_back('{32'h0000_0080, 3'd2, 32'h0000_0800, 1'b0}); // instr[7] -> imm[11]
        // J-type
        vecs.push_back('{32'h0020_0000, 3'd4, 32'h0000_0002, 1'b0});
        vecs.push_back('{32'hFFFF_F000, 3'd4, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{32'h7FFF_F000, 3'd4, 32'h000F_FFFE, 1'b0});
        vecs.push_back('{32'h8000_0000, 3'd4, 32'hFFF0_0000, 1'b0});
        vecs.push_back('{32'h0010_0000, 3'd4, 32'h0000_0800, 1'b0}); // instr[20] -> imm[11]
        vecs.push_back('{32'h0000_1000, 3'd4, 32'h0000_1000, 1'b0}); // instr[12] -> imm[12]
        // Undefined selector encodings
        vecs.push_back('{32'hFFFF_FFFF, 3'd5, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'hFFFF_FFFF, 3'd6, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'hFFFF_FFFF, 3'd7, 32'h0000_0000, 1'b1});

        // Hold reset from time zero.
        rst_ni    = 1'b0;
        instr_i   = 32'h0000_0000;
        imm_src_i = cpu_pkg::IMM_I;

        // Combinational path: no clock edge dependence, sample 1 ns after stimulus.
        for (int i = 0; i < vecs.size(); i++) begin
            instr_i   = vecs[i].instr;
            imm_src_i = cpu_pkg::imm_src_e'(vecs[i].src);
            #1;
            check($sformatf("vec%0d_imm", i), imm_o, vecs[i].exp_imm);
            check($sformatf("vec%0d_err", i), {31'd0, imm_src_err_o},
                  {31'd0, vecs[i].exp_err});
        end

        // Register stays clear while reset is held, even with clock edges and
        // a nonzero immediate on the input.
        instr_i   = 32'hFFF0_0000;
        imm_src_i = cpu_pkg::IMM_I;
        @(posedge clk_i);
        @(negedge clk_i);
        check("q_in_reset", imm_q_o, 32'h0000_0000);

        // Release reset and capture I-type 12'hFFF on the next edge.
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("q_capture_fff", imm_q_o, 32'hFFFF_FFFF);

        // New input between edges: imm_o follows at once, imm_q_o waits for the edge.
        instr_i = 32'h0010_0000;
        #1;
        check("comb_follows", imm_o, 32'h0000_0001);
        check("q_holds", imm_q_o, 32'hFFFF_FFFF);
        @(posedge clk_i);
        #1;
        check("q_capture_001", imm_q_o, 32'h0000_0001);

        // Mid-cycle reset clears the register without waiting for a clock edge.
        #2;
        rst_ni = 1'b0;
        #1;
        check("q_async_clear", imm_q_o, 32'h0000_0000);
        @(posedge clk_i);
        #1;
        check("q_held_clear", imm_q_o, 32'h0000_0000);

        // Undefined selector registers as zero after release.
        rst_ni    = 1'b1;
        instr_i   = 32'hFFFF_FFFF;
        imm_src_i = cpu_pkg::imm_src_e'(3'd6);
        #1;
        check("undef_imm", imm_o, 32'h0000_0000);
        check("undef_err", {31'd0, imm_src_err_o}, 32'h0000_0001);
        @(posedge clk_i);
        #1;
        check("q_undef", imm_q_o, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_imm_gen
